pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch front end of the single-cycle MIPS datapath.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents each fetched instruction with its PC and PC+4 to the decode/execute stage.
- Absorbs branch/jump redirects, including redirects that arrive while a fetch is outstanding.
- A one-entry skid buffer absorbs a fetch that completes while the consumer is stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; must be word-aligned.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset; asynchronous, active-low.
- stall_in  input  1  consumer not accepting inst_out this cycle.
- redirect_in  input  1  taken branch/jump; single-cycle pulse.
- target_in  input  32  redirect target; bits [1:0] ignored and forced to 00.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  32  fetch address; stable while imem_req_out is high and not yet acked.
- imem_ack_in  input  1  fetch complete; meaningful only while imem_req_out is high.
- imem_data_in  input  32  instruction word; valid with imem_ack_in.
- inst_valid_out  output  1  inst_out, pc_out and pc_plus4_out are valid.
- inst_out  output  32  fetched instruction.
- pc_out  output  32  address of inst_out.
- pc_plus4_out  output  32  pc_out + 4, modulo 2^32.

## Operation
- Handshake: a transfer occurs on any cycle with imem_req_out && imem_ack_in. Zero-wait acks (ack in the same cycle as req) are legal.
- Consumer accepts the output register on inst_valid_out && !stall_in.
- slot_free = !inst_valid_out || !stall_in.
- Register set: pc_q (next fetch PC), req_addr_q (outstanding address), output register, one-entry skid buffer.

State machine:
- IDLE:
  - Entered on reset; req=0. Leaves after 1 cycle.
  - Goes to FETCH with req_addr_q=pc_q.
  - With redirect: pc_q=target first.
- FETCH:
  - req=1, imem_addr_out=req_addr_q.
  - On ack with slot_free: load output register, pc_q+=4, next req_addr_q=pc_q+4, stay in FETCH.
  - On ack with !slot_free: load skid, pc_q+=4, go to HOLD.
  - No ack: hold.
- HOLD:
  - req=0.
  - When slot_free: skid→output register, go to FETCH.
- DRAIN:
  - req=1 at the stale address.
  - On ack: discard data, req_addr_q=pc_q, go to FETCH.

Redirect (highest priority; applies in every state):
- pc_q=target and req_addr_q=target.
- Clears inst_valid_out and skid valid on the same edge.
- In FETCH or DRAIN with no ack that cycle: go to DRAIN, since the request must complete.
- In FETCH or DRAIN with ack that cycle: discard data, go to FETCH.
- In HOLD or IDLE: go to FETCH.

Arithmetic and reset values:
- PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset values: imem_req_out=0, imem_addr_out=RESET_PC, inst_valid_out=0, inst_out=0, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4.
- Reset asserted mid-fetch abandons the request; the memory side must tolerate req dropping.

## Timing
- Latency: ack in cycle N → inst_valid_out high in N+1.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- First request is issued in the 2nd cycle after rst_n_in deasserts (IDLE lasts 1 cycle).
- Redirect in cycle N → first request to the target in N+1 if no fetch was outstanding; otherwise in the cycle after the stale ack.
- Output register and skid update only on clock edges; no combinational path from imem_data_in to inst_out.
- imem_req_out depends only on state (registered), not on stall_in.

## Structure
- Shared package mips_pkg holds:
  - state encoding (IDLE, FETCH, HOLD, DRAIN);
  - WORD_BYTES=4;
  - default RESET_PC.
- Sub-module fetch_skid: one-entry {inst, pc} buffer with load, unload and flush.
- The +4 incrementer is a plain 32-bit add.

## Test plan
- Reset release, zero-wait memory returning addr as data: inst_out sequence 0,4,8,12 on consecutive cycles with pc_out matching; imem_req_out=0 during reset.
- 3-cycle ack latency: req held and imem_addr_out stable for 3 cycles; one valid pulse per fetch.
- Redirect to 32'h0000_0100 while fetch of 0x8 is pending, ack 2 cycles later: stale data never valid; next imem_addr_out=0x100.
- stall_in held 4 cycles with inst 0x4 in the output register, ack for 0x8 arriving: 0x8 enters skid, req low; 0x4 then 0x8 delivered in order once stall drops, no loss or duplication.
- RESET_PC=32'hFFFF_FFFC: second fetch address is 0x0, and pc_plus4_out=0 for the first instruction.
- Redirect and ack in the same cycle while stalled with skid full: output and skid flushed; next request goes to the target.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch front end.
//   fetch_state_e    : fetch state machine encoding (IDLE, FETCH, HOLD, DRAIN)
//   WORD_BYTES       : instruction size in bytes (PC increment)
//   DEFAULT_RESET_PC : default PC after reset
//   word_align()     : clears bits [1:0] of an address
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_if
// Instruction-memory fetch bus (req/ack handshake).
//   req  : fetch request, driven by the fetch unit
//   addr : word address, stable while req is high and not yet acked
//   ack  : fetch complete, driven by memory; meaningful only while req is high
//   data : instruction word, valid with ack
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface pc_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );

endinterface

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// One-entry {inst, pc} holding buffer for a fetch that completes while the
// consumer is stalled.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   load_i           : capture inst_i/pc_i and mark the entry valid
//   unload_i         : entry consumed; mark invalid
//   flush_i          : discard the entry (wins over load and unload)
//   inst_i, pc_i     : entry data in
//   valid_o          : entry holds data
//   inst_o, pc_o     : entry data out
// ---------------------------------------------------------------------------
module fetch_skid (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        flush_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Program counter and instruction-fetch front end of the single-cycle MIPS
// datapath. Issues word fetches over a req/ack bus, presents each instruction
// with its PC and PC+4, absorbs branch/jump redirects (including ones that land
// while a fetch is outstanding) and parks one completed fetch in a skid buffer
// while the consumer is stalled.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   stall_in         : consumer not accepting inst_out this cycle
//   redirect_in      : taken branch/jump (single-cycle pulse)
//   target_in        : redirect target, bits [1:0] ignored
//   imem             : instruction-memory fetch bus (master side)
//   inst_valid_out   : inst_out / pc_out / pc_plus4_out valid
//   inst_out         : fetched instruction
//   pc_out           : address of inst_out
//   pc_plus4_out     : pc_out + 4 (wraps)
// ---------------------------------------------------------------------------
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [31:0]       target_in,
    pc_fetch_if.master        imem,
    output logic              inst_valid_out,
    output logic [31:0]       inst_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4_out
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;        // next fetch PC
    logic [31:0]  req_addr_q;  // address of the outstanding request
    logic         out_valid_q;
    logic [31:0]  out_inst_q;
    logic [31:0]  out_pc_q;

    logic         req_active;
    logic         slot_free;
    logic [31:0]  pc_inc_d;
    logic [31:0]  target_d;

    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_valid;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc;

    always_comb begin
        req_active  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        slot_free   = !out_valid_q || !stall_in;
        pc_inc_d    = pc_q + 32'(WORD_BYTES);
        target_d    = word_align(target_in);
        skid_flush  = redirect_in;
        skid_load   = !redirect_in && (state_q == ST_FETCH) && imem.ack && !slot_free;
        skid_unload = !redirect_in && (state_q == ST_HOLD) && slot_free;
    end

    // Request is a pure decode of the registered state: no path from stall_in.
    assign imem.req  = req_active;
    assign imem.addr = req_addr_q;

    fetch_skid u_skid (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .inst_i   (imem.data),
        .pc_i     (req_addr_q),
        .valid_o  (skid_valid),
        .inst_o   (skid_inst),
        .pc_o     (skid_pc)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= RESET_PC;
        end else begin
            // Consumer takes the output register; a load below overrides this.
            if (out_valid_q && !stall_in) begin
                out_valid_q <= 1'b0;
            end

            if (redirect_in) begin
                pc_q        <= target_d;
                out_valid_q <= 1'b0;
                if (req_active && !imem.ack) begin
                    // Outstanding request must finish at its original address,
                    // so req_addr_q keeps the stale address until DRAIN's ack
                    // copies the target across from pc_q.
                    state_q <= ST_DRAIN;
                end else begin
                    state_q    <= ST_FETCH;
                    req_addr_q <= target_d;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q    <= ST_FETCH;
                        req_addr_q <= pc_q;
                    end
                    ST_FETCH: begin
                        if (imem.ack) begin
                            pc_q       <= pc_inc_d;
                            req_addr_q <= pc_inc_d;
                            if (slot_free) begin
                                out_valid_q <= 1'b1;
                                out_inst_q  <= imem.data;
                                out_pc_q    <= req_addr_q;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (slot_free) begin
                            out_valid_q <= skid_valid;
                            out_inst_q  <= skid_inst;
                            out_pc_q    <= skid_pc;
                            state_q     <= ST_FETCH;
                        end
                    end
                    ST_DRAIN: begin
                        if (imem.ack) begin
                            req_addr_q <= pc_q;
                            state_q    <= ST_FETCH;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign inst_valid_out = out_valid_q;
    assign inst_out       = out_inst_q;
    assign pc_out         = out_pc_q;
    assign pc_plus4_out   = out_pc_q + 32'(WORD_BYTES);

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Directed bench for pc_fetch. Two instances: dut (RESET_PC = 0, memory with a
// programmable number of wait cycles) and dut_w (RESET_PC = 0xFFFF_FFFC,
// zero-wait memory). Both memories return the request address as data.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] target2 = '0;

    logic        valid, valid2;
    logic [31:0] inst, pc, pc4, inst2, pc2, pc42;

    int unsigned mem_wait = 0;
    int unsigned wait_cnt = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_fetch_if bus ();
    pc_fetch_if bus2 ();

    always #5 clk = ~clk;

    // Memory: ack after mem_wait idle request cycles, data = address.
    assign bus.ack   = bus.req && (wait_cnt >= mem_wait);
    assign bus.data  = bus.addr;
    assign bus2.ack  = bus2.req;
    assign bus2.data = bus2.addr;

    always @(posedge clk) begin
        if (!rst_n || !bus.req || bus.ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .stall_in       (stall),
        .redirect_in    (redirect),
        .target_in      (target),
        .imem           (bus),
        .inst_valid_out (valid),
        .inst_out       (inst),
        .pc_out         (pc),
        .pc_plus4_out   (pc4)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_in         (clk),
        .rst_n_in       (rst2_n),
        .stall_in       (stall2),
        .redirect_in    (redirect2),
        .target_in      (target2),
        .imem           (bus2),
        .inst_valid_out (valid2),
        .inst_out       (inst2),
        .pc_out         (pc2),
        .pc_plus4_out   (pc42)
    );

    task automatic do_reset(input int unsigned w);
        rst_n    = 1'b0;
        mem_wait = w;
        stall    = 1'b0;
        redirect = 1'b0;
        target   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req, bus.addr, valid, inst} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            $display("FAIL reset_bus_out: got req=%b addr=%h valid=%b inst=%h expected 0/00000000/0/00000000",
                     bus.req, bus.addr, valid, inst);
            errors++;
        end
        checks++;
        if ({pc, pc4} !== {32'h0, 32'h4}) begin
            $display("FAIL reset_pc: got pc=%h pc4=%h expected 00000000/00000004", pc, pc4);
            errors++;
        end
        checks++;
        if ({bus2.req, bus2.addr, pc2, pc42} !== {1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
            $display("FAIL reset_pc_wrap: got req=%b addr=%h pc=%h pc4=%h expected 0/fffffffc/fffffffc/00000000",
                     bus2.req, bus2.addr, pc2, pc42);
            errors++;
        end
        // Release and stream with zero-wait memory.
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req !== 1'b0) begin
            $display("FAIL idle_req: got %b expected 0", bus.req);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req, bus.addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL first_req: got req=%b addr=%h valid=%b expected 1/00000000/0", bus.req, bus.addr, valid);
            errors++;
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({valid, inst, pc, pc4} !== {1'b1, 32'(4 * k), 32'(4 * k), 32'(4 * k + 4)}) begin
                $display("FAIL stream_%0d: got valid=%b inst=%h pc=%h pc4=%h expected 1/%h/%h/%h",
                         k, valid, inst, pc, pc4, 32'(4 * k), 32'(4 * k), 32'(4 * k + 4));
                errors++;
            end
        end
    endtask

    task automatic test_latency;
        do_reset(2);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.req, bus.addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
                $display("FAIL lat_wait_%0d: got req=%b addr=%h valid=%b expected 1/00000000/0", e, bus.req, bus.addr, valid);
                errors++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, inst, bus.addr} !== {1'b1, 32'h0, 32'h4}) begin
            $display("FAIL lat_first: got valid=%b inst=%h addr=%h expected 1/00000000/00000004", valid, inst, bus.addr);
            errors++;
        end
        for (int k = 1; k <= 2; k++) begin
            for (int w = 0; w < 2; w++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if ({valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'(4 * k)}) begin
                    $display("FAIL lat_hold_%0d_%0d: got valid=%b req=%b addr=%h expected 0/1/%h",
                             k, w, valid, bus.req, bus.addr, 32'(4 * k));
                    errors++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({valid, inst, pc, bus.addr} !== {1'b1, 32'(4 * k), 32'(4 * k), 32'(4 * k + 4)}) begin
                $display("FAIL lat_data_%0d: got valid=%b inst=%h pc=%h addr=%h expected 1/%h/%h/%h",
                         k, valid, inst, pc, bus.addr, 32'(4 * k), 32'(4 * k), 32'(4 * k + 4));
                errors++;
            end
        end
        // Reset in the middle of a pending fetch drops the request at once.
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req, bus.addr, valid} !== {1'b0, 32'h0, 1'b0}) begin
            $display("FAIL reset_midfetch: got req=%b addr=%h valid=%b expected 0/00000000/0", bus.req, bus.addr, valid);
            errors++;
        end
    endtask

    task automatic test_redirect_pending;
        do_reset(2);
        repeat (7) @(posedge clk);
        #1 redirect = 1'b1;
        target = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if ({valid, inst, bus.req, bus.addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
            $display("FAIL redir_before: got valid=%b inst=%h req=%b addr=%h expected 1/00000004/1/00000008",
                     valid, inst, bus.req, bus.addr);
            errors++;
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            checks++;
            if ({valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'h8}) begin
                $display("FAIL redir_drain_%0d: got valid=%b req=%b addr=%h expected 0/1/00000008", e, valid, bus.req, bus.addr);
                errors++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if ({valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'h100}) begin
            $display("FAIL redir_target_req: got valid=%b req=%b addr=%h expected 0/1/00000100", valid, bus.req, bus.addr);
            errors++;
        end
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin
                $display("FAIL redir_no_stale_%0d: got valid=%b inst=%h expected valid 0", e, valid, inst);
                errors++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, inst, pc, pc4} !== {1'b1, 32'h100, 32'h100, 32'h104}) begin
            $display("FAIL redir_target_data: got valid=%b inst=%h pc=%h pc4=%h expected 1/00000100/00000100/00000104",
                     valid, inst, pc, pc4);
            errors++;
        end
    endtask

    task automatic test_stall_skid;
        do_reset(0);
        repeat (3) @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid, inst, bus.req, bus.addr} !== {1'b1, 32'h4, 1'b1, 32'h8}) begin
            $display("FAIL stall_start: got valid=%b inst=%h req=%b addr=%h expected 1/00000004/1/00000008",
                     valid, inst, bus.req, bus.addr);
            errors++;
        end
        for (int e = 4; e <= 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.req, valid, inst, pc} !== {1'b0, 1'b1, 32'h4, 32'h4}) begin
                $display("FAIL stall_hold_%0d: got req=%b valid=%b inst=%h pc=%h expected 0/1/00000004/00000004",
                         e, bus.req, valid, inst, pc);
                errors++;
            end
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, inst, pc, bus.req, bus.addr} !== {1'b1, 32'h8, 32'h8, 1'b1, 32'hC}) begin
            $display("FAIL stall_skid_out: got valid=%b inst=%h pc=%h req=%b addr=%h expected 1/00000008/00000008/1/0000000c",
                     valid, inst, pc, bus.req, bus.addr);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, inst, pc} !== {1'b1, 32'hC, 32'hC}) begin
            $display("FAIL stall_resume: got valid=%b inst=%h pc=%h expected 1/0000000c/0000000c", valid, inst, pc);
            errors++;
        end
    endtask

    task automatic test_wrap;
        @(posedge clk);
        #1 rst2_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus2.req, bus2.addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            $display("FAIL wrap_first_req: got req=%b addr=%h expected 1/fffffffc", bus2.req, bus2.addr);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid2, inst2, pc2, pc42, bus2.addr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            $display("FAIL wrap_first_inst: got valid=%b inst=%h pc=%h pc4=%h addr=%h expected 1/fffffffc/fffffffc/00000000/00000000",
                     valid2, inst2, pc2, pc42, bus2.addr);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid2, inst2, pc2, pc42} !== {1'b1, 32'h0, 32'h0, 32'h4}) begin
            $display("FAIL wrap_second_inst: got valid=%b inst=%h pc=%h pc4=%h expected 1/00000000/00000000/00000004",
                     valid2, inst2, pc2, pc42);
            errors++;
        end
    endtask

    task automatic test_redirect_flush;
        do_reset(0);
        repeat (3) @(posedge clk);
        #1 stall = 1'b1;
        repeat (2) @(posedge clk);
        #1 redirect = 1'b1;
        target = 32'h0000_0202;
        @(negedge clk);
        checks++;
        if ({bus.req, valid, inst} !== {1'b0, 1'b1, 32'h4}) begin
            $display("FAIL flush_hold: got req=%b valid=%b inst=%h expected 0/1/00000004", bus.req, valid, inst);
            errors++;
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'h200}) begin
            $display("FAIL flush_skid_target: got valid=%b req=%b addr=%h expected 0/1/00000200", valid, bus.req, bus.addr);
            errors++;
        end
        // Output full, stalled, ack of 0x204 arriving together with a redirect.
        @(posedge clk);
        #1 redirect = 1'b1;
        target = 32'h0000_0300;
        @(negedge clk);
        checks++;
        if ({valid, inst, pc, pc4, bus.addr} !== {1'b1, 32'h200, 32'h200, 32'h204, 32'h204}) begin
            $display("FAIL flush_target_data: got valid=%b inst=%h pc=%h pc4=%h addr=%h expected 1/00000200/00000200/00000204/00000204",
                     valid, inst, pc, pc4, bus.addr);
            errors++;
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, bus.req, bus.addr} !== {1'b0, 1'b1, 32'h300}) begin
            $display("FAIL flush_ack_redirect: got valid=%b req=%b addr=%h expected 0/1/00000300", valid, bus.req, bus.addr);
            errors++;
        end
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, inst, pc} !== {1'b1, 32'h300, 32'h300}) begin
            $display("FAIL flush_new_data: got valid=%b inst=%h pc=%h expected 1/00000300/00000300", valid, inst, pc);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid, inst, pc} !== {1'b1, 32'h304, 32'h304}) begin
            $display("FAIL flush_next_data: got valid=%b inst=%h pc=%h expected 1/00000304/00000304", valid, inst, pc);
            errors++;
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_redirect_pending;
        test_stall_skid;
        test_wrap;
        test_redirect_flush;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
